// File: rtl/match_ctrl.sv
// match_ctrl: match-level controller sitting downstream of the physics engine.
// It keeps score from the engine's rally results, freezes the engine for a
// pause between points, declares the match winner, and drives the engine's
// frame enable and active-low reset so every match starts from a clean state.
module match_ctrl #(
   parameter int WIN_SCORE    = 7,
   parameter int PAUSE_FRAMES = 90,
   parameter int SCORE_W      = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               start_btn,
   input  logic               game_over,
   input  logic [1:0]         winner,
   output logic               phys_en,
   output logic               phys_rst_n,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score,
   output logic               match_over,
   output logic [1:0]         match_winner,
   output logic [1:0]         state,
   output logic               point_flash
);

   // Pause counter is wide enough to hold PAUSE_FRAMES itself, so it never wraps.
   localparam int CNT_W = $clog2(PAUSE_FRAMES + 1);

   localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);
   localparam logic [SCORE_W-1:0] ONE_PT   = SCORE_W'(1);
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(PAUSE_FRAMES - 1);
   localparam logic [CNT_W-1:0]   ONE_CNT  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PLAY       = 2'd1,
      PAUSE      = 2'd2,
      MATCH_OVER = 2'd3
   } state_t;

   state_t             r_state;
   logic [SCORE_W-1:0] r_p1Score;
   logic [SCORE_W-1:0] r_p2Score;
   logic               r_matchOver;
   logic [1:0]         r_matchWinner;
   logic               r_physRstN;
   logic [CNT_W-1:0]   r_pauseCnt;
   logic               r_startQ;
   logic               r_goQ;

   state_t             w_stateNext;
   logic [SCORE_W-1:0] w_p1Next;
   logic [SCORE_W-1:0] w_p2Next;
   logic               w_matchOverNext;
   logic [1:0]         w_matchWinnerNext;
   logic [CNT_W-1:0]   w_pauseCntNext;

   logic               w_startRise;
   logic               w_goRise;
   logic [SCORE_W-1:0] w_p1Plus;
   logic [SCORE_W-1:0] w_p2Plus;

   // Edge detection on the start button and the engine's rally-ended flag, so
   // a level held across many cycles only acts once.
   assign w_startRise = start_btn & ~r_startQ;
   assign w_goRise    = game_over & ~r_goQ;

   // Saturating score increments: a score never climbs past WIN_SCORE.
   assign w_p1Plus = (r_p1Score >= WIN_VAL) ? WIN_VAL : (r_p1Score + ONE_PT);
   assign w_p2Plus = (r_p2Score >= WIN_VAL) ? WIN_VAL : (r_p2Score + ONE_PT);

   // Next-state, score and pause-counter logic; everything holds by default.
   always_comb begin
      w_stateNext       = r_state;
      w_p1Next          = r_p1Score;
      w_p2Next          = r_p2Score;
      w_matchOverNext   = r_matchOver;
      w_matchWinnerNext = r_matchWinner;
      w_pauseCntNext    = r_pauseCnt;

      case (r_state)
         IDLE: begin
            if (w_startRise) begin
               w_stateNext = PLAY;
            end
         end

         PLAY: begin
            if (w_goRise && (winner == 2'd1)) begin
               w_p1Next = w_p1Plus;
               if (w_p1Plus == WIN_VAL) begin
                  w_stateNext       = MATCH_OVER;
                  w_matchOverNext   = 1'b1;
                  w_matchWinnerNext = 2'd1;
               end else begin
                  w_stateNext    = PAUSE;
                  w_pauseCntNext = '0;
               end
            end else if (w_goRise && (winner == 2'd2)) begin
               w_p2Next = w_p2Plus;
               if (w_p2Plus == WIN_VAL) begin
                  w_stateNext       = MATCH_OVER;
                  w_matchOverNext   = 1'b1;
                  w_matchWinnerNext = 2'd2;
               end else begin
                  w_stateNext    = PAUSE;
                  w_pauseCntNext = '0;
               end
            end
         end

         PAUSE: begin
            if (frame_tick) begin
               if (r_pauseCnt >= LAST_CNT) begin
                  w_stateNext = PLAY;
               end else begin
                  w_pauseCntNext = r_pauseCnt + ONE_CNT;
               end
            end
         end

         MATCH_OVER: begin
            if (w_startRise) begin
               w_stateNext       = IDLE;
               w_p1Next          = '0;
               w_p2Next          = '0;
               w_matchOverNext   = 1'b0;
               w_matchWinnerNext = 2'd0;
            end
         end

         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // State register plus the held match result; the engine reset follows the
   // next state so it releases on the same edge that leaves IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_p1Score     <= '0;
         r_p2Score     <= '0;
         r_matchOver   <= 1'b0;
         r_matchWinner <= 2'd0;
         r_physRstN    <= 1'b0;
         r_pauseCnt    <= '0;
      end else begin
         r_state       <= w_stateNext;
         r_p1Score     <= w_p1Next;
         r_p2Score     <= w_p2Next;
         r_matchOver   <= w_matchOverNext;
         r_matchWinner <= w_matchWinnerNext;
         r_physRstN    <= (w_stateNext != IDLE);
         r_pauseCnt    <= w_pauseCntNext;
      end
   end

   // Delayed copies of the button and rally flag, tracked in every state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_startQ <= 1'b0;
         r_goQ    <= 1'b0;
      end else begin
         r_startQ <= start_btn;
         r_goQ    <= game_over;
      end
   end

   assign phys_en      = frame_tick & (r_state == PLAY);
   assign phys_rst_n   = r_physRstN;
   assign p1_score     = r_p1Score;
   assign p2_score     = r_p2Score;
   assign match_over   = r_matchOver;
   assign match_winner = r_matchWinner;
   assign state        = r_state;
   assign point_flash  = (r_state == PAUSE);

endmodule
